// File: rtl/mul4_acc.sv
// mul4_acc: accumulate stage for the 4x4 array multiplier.
//   Sums N_TERMS unsigned PW-bit products into one ACC_W-bit result. The
//   result is held on a valid/ready output port until it is taken.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   clr        synchronous clear: drop the partial sum or the pending result
//   in_valid   in_p carries a product this cycle
//   in_ready   stage accepts a product this cycle
//   in_p       unsigned product (PW bits)
//   out_valid  out_sum/out_ovf hold a completed result
//   out_ready  consumer takes the result this cycle
//   out_sum    sum of N_TERMS products, modulo 2^ACC_W
//   out_ovf    some add in this result carried out of ACC_W bits
//   busy       a block is partly summed or a result is pending
module mul4_acc #(
  parameter int PW      = 8,
  parameter int ACC_W   = 12,
  parameter int N_TERMS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(N_TERMS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               accept;
  logic [ACC_W:0]     sum_ext;

  // Zero-extended add; the top bit is the carry out of the ACC_W-bit sum.
  function automatic logic [ACC_W:0] add_carry(input logic [ACC_W-1:0] a,
                                               input logic [PW-1:0]    p);
    return {1'b0, a} + {{(ACC_W + 1 - PW){1'b0}}, p};
  endfunction

  // clr blocks the input so a product offered in the clear cycle is dropped.
  assign in_ready  = (state_q == ST_ACC) && !clr;
  assign accept    = in_valid && in_ready;
  assign sum_ext   = add_carry(acc_q, in_p);

  assign out_valid = (state_q == ST_HOLD);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign busy      = (count_q != '0) || (state_q == ST_HOLD);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    if (clr) begin
      state_d = ST_ACC;
      acc_d   = '0;
      ovf_d   = 1'b0;
      count_d = '0;
    end else if (state_q == ST_ACC) begin
      if (accept) begin
        acc_d = sum_ext[ACC_W-1:0];
        ovf_d = ovf_q | sum_ext[ACC_W];
        if (count_q == LAST_CNT) begin
          count_d = '0;
          state_d = ST_HOLD;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
    end else if (out_ready) begin
      // Result taken; the next block starts summing from zero.
      state_d = ST_ACC;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

endmodule
